// File: rtl/riscv_fetch_unit_pkg.sv
// Shared widths, fetch step, FSM encodings and queue entry type for the fetch front end.
package riscv_fetch_unit_pkg;

  localparam int XLEN       = 32;
  localparam int ILEN       = 32;
  localparam int FETCH_STEP = 4;

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_unit_buffer.sv
// Two-entry FIFO of {pc, instr} pairs sitting between instruction memory and decode.
module riscv_fetch_buffer
  import riscv_fetch_unit_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  fetch_entry_t i_push_data,
  input  logic         i_pop,
  input  logic         i_flush,
  output logic [1:0]   o_count,
  output fetch_entry_t o_head
);

  fetch_entry_t mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;

  always_comb begin
    count_d = count_q + {1'b0, i_push} - {1'b0, i_pop};
    if (i_flush) count_d = 2'd0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      count_q <= count_d;
      if (i_flush) begin
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
      end else begin
        if (i_push) begin
          mem_q[wr_ptr_q] <= i_push_data;
          wr_ptr_q        <= ~wr_ptr_q;
        end
        if (i_pop) rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  assign o_count = count_q;
  assign o_head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/riscv_fetch_unit.sv
// Fetch front end: PC generation, credit-limited imem requests, redirect flush.
// Optional RISCV_FETCH_PERF_EN adds pop / discarded-word counters.
module riscv_fetch_unit
  import riscv_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [31:0]     i_imem_rdata,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  input  logic            i_stall,
  output logic            o_fetch_valid,
  output logic [XLEN-1:0] o_fetch_pc,
  output logic [XLEN-1:0] o_fetch_instr,
  output logic [XLEN-1:0] o_fetch_pc_next,
  output logic            o_fetch_clr
`ifdef RISCV_FETCH_PERF_EN
  ,
  output logic [31:0]     o_perf_fetched,
  output logic [31:0]     o_perf_dropped
`endif
);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [1:0]      outstanding_q, outstanding_d;
  logic [1:0]      drop_q, drop_d;

  logic [1:0]      buf_count;
  fetch_entry_t    buf_head;
  logic [2:0]      credit_used;
  logic            grant, push, pop, discard;

  assign credit_used   = {1'b0, outstanding_q} + {1'b0, buf_count};
  assign o_imem_req    = (state_q == RUN) && (credit_used < 3'(MAX_OUTSTANDING)) && !i_redirect;
  assign o_imem_addr   = req_pc_q;
  assign grant         = o_imem_req && i_imem_gnt;
  assign discard       = i_imem_rvalid && (drop_q != 2'd0);
  assign push          = i_imem_rvalid && (drop_q == 2'd0) && !i_redirect;
  assign o_fetch_valid = (buf_count != 2'd0);
  assign pop           = o_fetch_valid && !i_stall && !i_redirect;
  assign o_fetch_clr   = i_redirect;

  riscv_fetch_buffer u_buffer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_push     (push),
    .i_push_data({resp_pc_q, i_imem_rdata}),
    .i_pop      (pop),
    .i_flush    (i_redirect),
    .o_count    (buf_count),
    .o_head     (buf_head)
  );

  // A redirect overrides everything; responses still in flight become the drop count.
  always_comb begin
    outstanding_d = outstanding_q + {1'b0, grant} - {1'b0, i_imem_rvalid};
    req_pc_d      = grant ? req_pc_q + XLEN'(FETCH_STEP) : req_pc_q;
    resp_pc_d     = push ? resp_pc_q + XLEN'(FETCH_STEP) : resp_pc_q;
    drop_d        = discard ? drop_q - 2'd1 : drop_q;
    state_d       = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      FLUSH:   if (drop_d == 2'd0) state_d = RUN;
      default: state_d = state_q;
    endcase
    if (i_redirect) begin
      req_pc_d  = {i_redirect_pc[XLEN-1:2], 2'b00};
      resp_pc_d = {i_redirect_pc[XLEN-1:2], 2'b00};
      drop_d    = outstanding_d;
      state_d   = (outstanding_d != 2'd0) ? FLUSH : RUN;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= BOOT;
      req_pc_q      <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= 2'd0;
      drop_q        <= 2'd0;
    end else begin
      state_q       <= state_d;
      req_pc_q      <= req_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  // Head fields read as zero while the queue is empty.
  assign o_fetch_pc      = o_fetch_valid ? buf_head.pc : '0;
  assign o_fetch_instr   = o_fetch_valid ? XLEN'(buf_head.instr) : '0;
  assign o_fetch_pc_next = o_fetch_valid ? buf_head.pc + XLEN'(FETCH_STEP) : '0;

`ifdef RISCV_FETCH_PERF_EN
  logic [31:0] fetched_q, dropped_q;
  logic [31:0] dropped_inc;

  always_comb begin
    dropped_inc = 32'(discard);
    if (i_redirect)
      dropped_inc = dropped_inc + 32'(buf_count) + 32'(i_imem_rvalid && (drop_q == 2'd0));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fetched_q <= '0;
      dropped_q <= '0;
    end else begin
      fetched_q <= fetched_q + 32'(pop);
      dropped_q <= dropped_q + dropped_inc;
    end
  end

  assign o_perf_fetched = fetched_q;
  assign o_perf_dropped = dropped_q;
`else
  // Counters compiled out; no perf ports exist in this build.
`endif

endmodule
